// File: rtl/qoa_predict_seq_if.sv
// Bundle of the prediction sequencer's handshake, shared-adder and sample-output signals.
// The slave side is the sequencer; the master side is the product source, adder and sink.
interface qoa_predict_seq_if;
    logic               start;
    logic signed [31:0] residual;
    logic               term_req;
    logic [2:0]         term_idx;
    logic               term_valid;
    logic signed [31:0] term_data;
    logic signed [31:0] add_a;
    logic signed [31:0] add_b;
    logic signed [31:0] add_sum;
    logic               busy;
    logic               done;
    logic signed [15:0] sample;

    modport master (
        output start, residual, term_valid, term_data, add_sum,
        input  term_req, term_idx, add_a, add_b, busy, done, sample
    );

    modport slave (
        input  start, residual, term_valid, term_data, add_sum,
        output term_req, term_idx, add_a, add_b, busy, done, sample
    );
endinterface

// File: rtl/qoa_predict_seq.sv
// QOA sample predictor: accumulates NTERMS LMS product terms through the shared adder,
// scales the sum, adds the residual through the same adder and clamps to 16 bits.
module qoa_predict_seq #(
    parameter int NTERMS = 4,
    parameter int SHIFT  = 13
) (
    input  logic             clk,
    input  logic             rst,
    qoa_predict_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RESID = 2'd2
    } state_t;

    localparam logic [2:0] K_LAST = 3'(NTERMS - 1);

    state_t             state_reg, state_next;
    logic signed [31:0] acc_reg, acc_next;
    logic signed [31:0] res_reg, res_next;
    logic [2:0]         k_reg, k_next;
    logic signed [15:0] sample_reg, sample_next;
    logic               done_reg;
    logic signed [15:0] clamped;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            acc_reg    <= '0;
            res_reg    <= '0;
            k_reg      <= '0;
            sample_reg <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            acc_reg    <= acc_next;
            res_reg    <= res_next;
            k_reg      <= k_next;
            sample_reg <= sample_next;
            done_reg   <= (state_reg == RESID);
        end
    end

    // Saturation happens only here; everything upstream wraps mod 2^32.
    always_comb begin
        if (bus.add_sum > 32'sd32767)
            clamped = 16'sh7fff;
        else if (bus.add_sum < -32'sd32768)
            clamped = 16'sh8000;
        else
            clamped = bus.add_sum[15:0];
    end

    always_comb begin
        state_next   = state_reg;
        acc_next     = acc_reg;
        res_next     = res_reg;
        k_next       = k_reg;
        sample_next  = sample_reg;
        bus.term_req = 1'b0;
        bus.term_idx = '0;
        bus.add_a    = '0;
        bus.add_b    = '0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    acc_next   = '0;
                    res_next   = bus.residual;
                    k_next     = '0;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                bus.term_req = 1'b1;
                bus.term_idx = k_reg;
                bus.add_a    = acc_reg;
                bus.add_b    = bus.term_data;
                if (bus.term_valid) begin
                    acc_next = bus.add_sum;
                    k_next   = k_reg + 3'd1;
                    if (k_reg == K_LAST)
                        state_next = RESID;
                end
            end
            RESID: begin
                bus.add_a   = acc_reg >>> SHIFT;
                bus.add_b   = res_reg;
                sample_next = clamped;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.busy   = (state_reg != IDLE);
    assign bus.done   = done_reg;
    assign bus.sample = sample_reg;
endmodule

// File: tb/tb_qoa_predict_seq.sv
// Directed bench for qoa_predict_seq: a vector table of term sets and residuals plus
// hand-written sequences for start-while-busy, start-on-done and mid-fetch reset.
module tb_qoa_predict_seq;
    localparam int NT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    qoa_predict_seq_if bus();

    qoa_predict_seq #(.NTERMS(NT), .SHIFT(13)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Shared adder lives outside the sequencer.
    assign bus.add_sum = bus.add_a + bus.add_b;

    typedef struct {
        string       name;
        logic [3:0][31:0] terms;
        logic [31:0] residual;
        int          waits;
        logic [31:0] exp_sample;
        int          exp_cycle;
    } vec_t;

    vec_t vecs[$];

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] feed_terms [8];
    int          feed_wait = 0;
    int          wait_left = 0;
    int          idx_log [512];
    int          n_log = 0;

    // Product source: inserts feed_wait idle cycles before each term, logs every index served.
    always @(negedge clk) begin
        if (!bus.term_req) begin
            bus.term_valid = 1'b0;
            wait_left      = feed_wait;
        end else if (wait_left > 0) begin
            bus.term_valid = 1'b0;
            wait_left--;
        end else begin
            bus.term_valid = 1'b1;
            bus.term_data  = feed_terms[bus.term_idx];
            if (n_log < 512) begin
                idx_log[n_log] = int'(bus.term_idx);
                n_log++;
            end
            wait_left = feed_wait;
        end
    end

    task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)",
                     what, $signed(act), act, $signed(exp), exp);
        end
    endtask

    function automatic logic [31:0] sx(input logic [15:0] s);
        return {{16{s[15]}}, s};
    endfunction

    task automatic add_vec(input string name, input logic [31:0] t3, input logic [31:0] t2,
                           input logic [31:0] t1, input logic [31:0] t0, input logic [31:0] res,
                           input int waits, input logic [31:0] exp_s, input int exp_c);
        vec_t v;
        v.name       = name;
        v.terms      = {t3, t2, t1, t0};
        v.residual   = res;
        v.waits      = waits;
        v.exp_sample = exp_s;
        v.exp_cycle  = exp_c;
        vecs.push_back(v);
    endtask

    task automatic set_feed(input logic [3:0][31:0] t, input int waits);
        for (int i = 0; i < 8; i++)
            feed_terms[i] = (i < 4) ? t[i] : 32'd0;
        feed_wait = waits;
    endtask

    task automatic run_vec(input vec_t v);
        int cyc;
        int base;
        int done_cyc;
        set_feed(v.terms, v.waits);
        @(negedge clk);
        base          = n_log;
        bus.start     = 1'b1;
        bus.residual  = v.residual;
        @(posedge clk);
        cyc      = 0;
        done_cyc = -1;
        while (done_cyc < 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            bus.start = 1'b0;
            if (cyc == 1)
                chk($sformatf("%s busy_c1", v.name), 32'(bus.busy), 32'd1);
            if (bus.done)
                done_cyc = cyc;
        end
        $display("vec %-10s res=%0d -> sample=%0d done_cycle=%0d", v.name,
                 $signed(v.residual), bus.sample, done_cyc);
        chk($sformatf("%s done_cycle", v.name), 32'(done_cyc), 32'(v.exp_cycle));
        chk($sformatf("%s sample", v.name), sx(bus.sample), v.exp_sample);
        chk($sformatf("%s busy_at_done", v.name), 32'(bus.busy), 32'd0);
        chk($sformatf("%s nterms", v.name), 32'(n_log - base), 32'(NT));
        for (int j = 0; j < NT; j++)
            chk($sformatf("%s term_idx%0d", v.name, j), 32'(idx_log[base + j]), 32'(j));
        @(negedge clk);
        chk($sformatf("%s done_pulse", v.name), 32'(bus.done), 32'd0);
        chk($sformatf("%s sample_hold", v.name), sx(bus.sample), v.exp_sample);
    endtask

    // Starts a prediction at edge 0, then drives start in the cycles flagged by mask.
    task automatic run_pulses(input string what, input logic [31:0] mask, input logic [31:0] res2,
                              input int ncyc, output int ndone, output int last_done);
        int cyc;
        set_feed({32'd8192, 32'd8192, 32'd8192, 32'd8192}, 0);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.residual = 32'd10;
        @(posedge clk);
        cyc       = 0;
        ndone     = 0;
        last_done = -1;
        repeat (ncyc) begin
            @(negedge clk);
            cyc++;
            bus.start = mask[cyc];
            if (mask[cyc])
                bus.residual = res2;
            if (bus.done) begin
                ndone++;
                last_done = cyc;
            end
        end
        bus.start = 1'b0;
        $display("seq %-12s dones=%0d last_done_cycle=%0d sample=%0d", what, ndone, last_done, bus.sample);
    endtask

    initial begin
        int nd;
        int ld;
        bus.start    = 1'b0;
        bus.residual = '0;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        $display("reset: term_req=%0b term_idx=%0d busy=%0b done=%0b sample=%0d",
                 bus.term_req, bus.term_idx, bus.busy, bus.done, bus.sample);
        chk("rst term_req", 32'(bus.term_req), 32'd0);
        chk("rst term_idx", 32'(bus.term_idx), 32'd0);
        chk("rst add_a", bus.add_a, 32'd0);
        chk("rst add_b", bus.add_b, 32'd0);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        chk("rst sample", sx(bus.sample), 32'd0);
        rst = 1'b0;

        add_vec("basic", 32'd8192, 32'd8192, 32'd8192, 32'd8192, 32'd10, 0, 32'd14, 6);
        add_vec("neg", 32'hFFFFE000, 32'hFFFFE000, 32'hFFFFE000, 32'hFFFFE000,
                32'hFFFFFFFF, 0, 32'hFFFFFFFB, 6);
        add_vec("floor", 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd0, 0, 32'hFFFFFFFF, 6);
        add_vec("sat_pos", 32'd0, 32'd0, 32'd0, 32'd0, 32'd40000, 0, 32'd32767, 6);
        add_vec("sat_neg", 32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF63C0, 0, 32'hFFFF8000, 6);
        add_vec("wrap", 32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000,
                32'd1234, 0, 32'd1234, 6);
        add_vec("mixed", 32'd70000, 32'd5000, 32'hFFFF8AD0, 32'd100000, 32'd300, 0, 32'd317, 6);
        add_vec("waits", 32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 2, 32'd0, 14);

        foreach (vecs[i])
            run_vec(vecs[i]);

        run_pulses("start_busy", 32'h0000_0014, 32'd999, 20, nd, ld);
        chk("start_busy ndone", 32'(nd), 32'd1);
        chk("start_busy done_cycle", 32'(ld), 32'd6);
        chk("start_busy sample", sx(bus.sample), 32'd14);

        run_pulses("start_on_done", 32'h0000_0040, 32'hFFFFFFEC, 20, nd, ld);
        chk("start_on_done ndone", 32'(nd), 32'd2);
        chk("start_on_done done_cycle", 32'(ld), 32'd12);
        chk("start_on_done sample", sx(bus.sample), 32'hFFFFFFF0);

        // Reset while k = 2 in FETCH; the partial sum must be discarded.
        set_feed({32'd8192, 32'd8192, 32'd8192, 32'd8192}, 0);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.residual = 32'd10;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst term_idx_before", 32'(bus.term_idx), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("midrst: busy=%0b term_req=%0b done=%0b sample=%0d",
                 bus.busy, bus.term_req, bus.done, bus.sample);
        chk("midrst busy", 32'(bus.busy), 32'd0);
        chk("midrst term_req", 32'(bus.term_req), 32'd0);
        chk("midrst sample", sx(bus.sample), 32'd0);
        chk("midrst done", 32'(bus.done), 32'd0);
        nd = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done)
                nd++;
        end
        chk("midrst no_done", 32'(nd), 32'd0);
        run_vec(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
